// File: rtl/video_ctrl_pkg.sv
// Shared types and constants for the video output mode controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: mode_state_t FSM encoding, SWITCH_CNT_W, cnt_w() counter-width helper.
package video_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      WAIT_EOF   = 2'd1,
      RESET_HOLD = 2'd2,
      MUTE       = 2'd3
   } mode_state_t;

   localparam int SWITCH_CNT_W = 8;

   // Bits needed to hold values 0..max_val, never less than one bit.
   function automatic int cnt_w(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single level signal entering the local clock domain.
// Latency: 2 clk_i cycles from d_i to q_o.
// Backpressure: none; level signal, no handshake.
// Ports:
//   clk_i  in   destination clock
//   rst_i  in   asynchronous active-high reset, loads RESET_VAL into both flops
//   d_i    in   asynchronous level input
//   q_o    out  synchronised level
module sync_2ff #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/video_output_mode_ctrl.sv
// Glitch-free HDMI/DVI mode switch sequencer: applies a requested mode only at end of frame.
// Latency: request seen 2 cycles after dvi_req_i (sync), blank 1 cycle later; mode applied on eof.
// Backpressure: none; dvi_req_i is a level held until applied, withdrawn requests are dropped.
// Ports:
//   clk_pixel_i      in   pixel clock
//   reset_i          in   asynchronous active-high reset
//   dvi_req_i        in   requested mode (1 = DVI), any clock domain
//   cx_i / cy_i      in   current pixel position from video_output
//   rgb_in_i         in   pixel from the VDP
//   rgb_out_o        out  pixel to video_output, zero while blanked
//   dvi_output_o     out  mode select to video_output
//   core_reset_o     out  synchronous reset to the encoder cores
//   audio_mute_o     out  audio mute, mirrors blank
//   blank_o          out  video blanked
//   busy_o           out  sequencer not in RUN
//   switch_count_o   out  completed switches, wraps
module video_output_mode_ctrl
   import video_ctrl_pkg::*;
#(
   parameter int BIT_WIDTH    = 10,
   parameter int BIT_HEIGHT   = 10,
   parameter int LAST_X       = 799,
   parameter int LAST_Y       = 524,
   parameter int RESET_CYCLES = 16,
   parameter int MUTE_FRAMES  = 2,
   parameter bit DVI_DEFAULT  = 1'b0
) (
   input  logic                    clk_pixel_i,
   input  logic                    reset_i,
   input  logic                    dvi_req_i,
   input  logic [BIT_WIDTH-1:0]    cx_i,
   input  logic [BIT_HEIGHT-1:0]   cy_i,
   input  logic [23:0]             rgb_in_i,
   output logic [23:0]             rgb_out_o,
   output logic                    dvi_output_o,
   output logic                    core_reset_o,
   output logic                    audio_mute_o,
   output logic                    blank_o,
   output logic                    busy_o,
   output logic [SWITCH_CNT_W-1:0] switch_count_o
);

   localparam int RST_W = cnt_w(RESET_CYCLES - 1);
   localparam int FRM_W = cnt_w(MUTE_FRAMES);

   localparam logic [RST_W-1:0]      RST_LOAD = RST_W'(RESET_CYCLES - 1);
   localparam logic [FRM_W-1:0]      FRM_LAST = FRM_W'(MUTE_FRAMES);
   localparam logic [BIT_WIDTH-1:0]  LX       = BIT_WIDTH'(LAST_X);
   localparam logic [BIT_HEIGHT-1:0] LY       = BIT_HEIGHT'(LAST_Y);

   logic req_s;

   mode_state_t             state_q,      state_d;
   logic                    dvi_q,        dvi_d;
   logic                    core_reset_q, core_reset_d;
   logic                    blank_q,      blank_d;
   logic [SWITCH_CNT_W-1:0] switch_cnt_q, switch_cnt_d;
   logic [RST_W-1:0]        rst_cnt_q,    rst_cnt_d;
   logic [FRM_W-1:0]        frame_cnt_q,  frame_cnt_d;
   // Set while the sequence following reset is still running, so that its
   // pass through MUTE is not counted as a completed switch.
   logic                    boot_q,       boot_d;
   logic                    busy_q;
   logic                    eof_q;
   logic [FRM_W-1:0]        frame_inc;

   sync_2ff #(
      .RESET_VAL (DVI_DEFAULT)
   ) u_req_sync (
      .clk_i (clk_pixel_i),
      .rst_i (reset_i),
      .d_i   (dvi_req_i),
      .q_o   (req_s)
   );

   always_comb begin
      state_d      = state_q;
      dvi_d        = dvi_q;
      core_reset_d = core_reset_q;
      blank_d      = blank_q;
      switch_cnt_d = switch_cnt_q;
      rst_cnt_d    = rst_cnt_q;
      frame_cnt_d  = frame_cnt_q;
      boot_d       = boot_q;
      frame_inc    = frame_cnt_q + 1'b1;

      case (state_q)
         RUN: begin
            if (req_s != dvi_q) begin
               state_d = WAIT_EOF;
               blank_d = 1'b1;
            end else begin
               blank_d = 1'b0;
            end
         end

         WAIT_EOF: begin
            // A withdrawn request wins over an eof arriving in the same cycle.
            if (req_s == dvi_q) begin
               state_d = RUN;
               blank_d = 1'b0;
            end else if (eof_q) begin
               state_d      = RESET_HOLD;
               dvi_d        = req_s;
               core_reset_d = 1'b1;
               rst_cnt_d    = RST_LOAD;
            end
         end

         RESET_HOLD: begin
            // cx/cy are meaningless while the cores are held, so eof is ignored.
            if (rst_cnt_q == '0) begin
               state_d      = MUTE;
               core_reset_d = 1'b0;
               frame_cnt_d  = '0;
            end else begin
               rst_cnt_d = rst_cnt_q - 1'b1;
            end
         end

         MUTE: begin
            if (eof_q) begin
               frame_cnt_d = frame_inc;
               if (frame_inc == FRM_LAST) begin
                  state_d = RUN;
                  blank_d = 1'b0;
                  boot_d  = 1'b0;
                  if (!boot_q) begin
                     switch_cnt_d = switch_cnt_q + 1'b1;
                  end
               end
            end
         end

         default: begin
            state_d = RESET_HOLD;
         end
      endcase
   end

   always_ff @(posedge clk_pixel_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= RESET_HOLD;
         dvi_q        <= DVI_DEFAULT;
         core_reset_q <= 1'b1;
         blank_q      <= 1'b1;
         busy_q       <= 1'b1;
         switch_cnt_q <= '0;
         rst_cnt_q    <= RST_LOAD;
         frame_cnt_q  <= '0;
         boot_q       <= 1'b1;
         eof_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         dvi_q        <= dvi_d;
         core_reset_q <= core_reset_d;
         blank_q      <= blank_d;
         busy_q       <= (state_d != RUN);
         switch_cnt_q <= switch_cnt_d;
         rst_cnt_q    <= rst_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         boot_q       <= boot_d;
         eof_q        <= (cx_i == LX) && (cy_i == LY);
      end
   end

   assign rgb_out_o      = blank_q ? 24'h000000 : rgb_in_i;
   assign audio_mute_o   = blank_q;
   assign blank_o        = blank_q;
   assign busy_o         = busy_q;
   assign dvi_output_o   = dvi_q;
   assign core_reset_o   = core_reset_q;
   assign switch_count_o = switch_cnt_q;

endmodule

// File: tb/tb_video_output_mode_ctrl.sv
module tb_video_output_mode_ctrl;
   import video_ctrl_pkg::*;

   localparam logic [9:0] LX = 10'd799;
   localparam logic [9:0] LY = 10'd524;
   localparam int         RC = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        dvi_req;
   logic [9:0]  cx;
   logic [9:0]  cy;
   logic [23:0] rgb_in;
   logic [23:0] rgb_out_o;
   logic        dvi_output_o;
   logic        core_reset_o;
   logic        audio_mute_o;
   logic        blank_o;
   logic        busy_o;
   logic [7:0]  switch_count_o;

   typedef struct packed {
      logic       dvi;
      logic [7:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   logic        exp_dvi;
   logic [7:0]  exp_cnt;

   always #5 clk = ~clk;

   video_output_mode_ctrl dut (
      .clk_pixel_i    (clk),
      .reset_i        (rst),
      .dvi_req_i      (dvi_req),
      .cx_i           (cx),
      .cy_i           (cy),
      .rgb_in_i       (rgb_in),
      .rgb_out_o      (rgb_out_o),
      .dvi_output_o   (dvi_output_o),
      .core_reset_o   (core_reset_o),
      .audio_mute_o   (audio_mute_o),
      .blank_o        (blank_o),
      .busy_o         (busy_o),
      .switch_count_o (switch_count_o)
   );

   initial begin
      #900000;
      $display("FAIL watchdog: observed no finish, required finish before 900000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle end-of-frame position; returns after the FSM has reacted.
   task automatic pulse_eof();
      cx = LX;
      cy = LY;
      @(negedge clk);
      cx = 10'd0;
      cy = 10'd100;
      @(negedge clk);
   endtask

   task automatic measure_reset(output int n);
      n = 0;
      while (core_reset_o && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   // From RUN: drive a new request and check blank rises exactly after the sync delay.
   task automatic start_switch(input logic req);
      dvi_req = req;
      tick(2);
      chk("blank_before_sync", 32'(blank_o), 0);
      tick(1);
      chk("blank_after_sync", 32'(blank_o), 1);
      chk("busy_wait_eof", 32'(busy_o), 1);
      chk("mute_wait_eof", 32'(audio_mute_o), 1);
      chk("dvi_held", 32'(dvi_output_o), 32'(exp_dvi));
      chk("rgb_blanked", 32'(rgb_out_o), 0);
   endtask

   // Two blanked frames after the core reset; pops the scoreboard on return to RUN.
   task automatic mute_phase(input bit toggle, input logic toggle_val);
      exp_t e;
      chk("blank_in_mute", 32'(blank_o), 1);
      chk("busy_in_mute", 32'(busy_o), 1);
      pulse_eof();
      chk("blank_after_eof1", 32'(blank_o), 1);
      chk("busy_after_eof1", 32'(busy_o), 1);
      if (toggle) begin
         dvi_req = toggle_val;
         tick(4);
         chk("mute_ignores_req_dvi", 32'(dvi_output_o), 32'(exp_dvi));
         chk("mute_ignores_req_blank", 32'(blank_o), 1);
      end
      pulse_eof();
      n_chk++;
      assert (sb_q.size() != 0) else begin
         n_fail++;
         $error("FAIL sb_underflow: observed %0d entries required at least 1", sb_q.size());
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("sb_dvi", 32'(dvi_output_o), 32'(e.dvi));
         chk("sb_count", 32'(switch_count_o), 32'(e.cnt));
      end
      chk("blank_run", 32'(blank_o), 0);
      chk("busy_run", 32'(busy_o), 0);
      chk("rgb_pass_run", 32'(rgb_out_o), 32'(rgb_in));
   endtask

   // From WAIT_EOF: eof applies the mode, then core reset and mute.
   task automatic finish_switch(input logic new_dvi);
      int n;
      tick(4);
      chk("dvi_before_eof", 32'(dvi_output_o), 32'(exp_dvi));
      chk("core_reset_before_eof", 32'(core_reset_o), 0);
      pulse_eof();
      exp_dvi = new_dvi;
      chk("dvi_at_eof", 32'(dvi_output_o), 32'(exp_dvi));
      chk("core_reset_at_eof", 32'(core_reset_o), 1);
      measure_reset(n);
      chk("core_reset_len", 32'(n), RC);
      mute_phase(1'b0, 1'b0);
   endtask

   initial begin
      int   n;
      logic r;
      logic cr_seen;

      // 1: reset values and boot sequence
      rst     = 1'b1;
      dvi_req = 1'b0;
      cx      = 10'd0;
      cy      = 10'd100;
      rgb_in  = 24'hA5C3F0;
      exp_dvi = 1'b0;
      exp_cnt = 8'd0;
      tick(3);
      chk("reset_core_reset", 32'(core_reset_o), 1);
      chk("reset_blank", 32'(blank_o), 1);
      chk("reset_busy", 32'(busy_o), 1);
      chk("reset_mute", 32'(audio_mute_o), 1);
      chk("reset_dvi", 32'(dvi_output_o), 0);
      chk("reset_count", 32'(switch_count_o), 0);
      chk("reset_rgb", 32'(rgb_out_o), 0);
      sb_q.push_back('{dvi: 1'b0, cnt: 8'd0});
      rst = 1'b0;
      measure_reset(n);
      chk("boot_core_reset_len", 32'(n), RC);
      mute_phase(1'b0, 1'b0);

      // 6: rgb pass-through is combinational
      rgb_in = 24'h123456;
      #1;
      chk("rgb_same_cycle_a", 32'(rgb_out_o), 32'h123456);
      rgb_in = 24'hA5C3F0;
      #1;
      chk("rgb_same_cycle_b", 32'(rgb_out_o), 32'hA5C3F0);
      tick(1);

      // 3: request withdrawn before eof
      dvi_req = 1'b1;
      cr_seen = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         cr_seen = cr_seen | core_reset_o;
         if (i == 3) chk("withdraw_blank_pulse", 32'(blank_o), 1);
         if (i == 10) dvi_req = 1'b0;
      end
      chk("withdraw_blank_clear", 32'(blank_o), 0);
      chk("withdraw_busy_clear", 32'(busy_o), 0);
      chk("withdraw_no_core_reset", 32'(cr_seen), 0);
      chk("withdraw_dvi", 32'(dvi_output_o), 0);
      chk("withdraw_count", 32'(switch_count_o), 32'(exp_cnt));

      // 2: HDMI -> DVI switch
      start_switch(1'b1);
      sb_q.push_back('{dvi: 1'b1, cnt: exp_cnt + 8'd1});
      exp_cnt = exp_cnt + 8'd1;
      finish_switch(1'b1);

      // 4: request toggled during MUTE is deferred to RUN
      start_switch(1'b0);
      sb_q.push_back('{dvi: 1'b0, cnt: exp_cnt + 8'd1});
      exp_cnt = exp_cnt + 8'd1;
      tick(4);
      pulse_eof();
      exp_dvi = 1'b0;
      chk("t4_dvi_at_eof", 32'(dvi_output_o), 0);
      measure_reset(n);
      chk("t4_core_reset_len", 32'(n), RC);
      mute_phase(1'b1, 1'b1);
      tick(1);
      chk("t4_reenter_wait_blank", 32'(blank_o), 1);
      chk("t4_reenter_wait_busy", 32'(busy_o), 1);
      sb_q.push_back('{dvi: 1'b1, cnt: exp_cnt + 8'd1});
      exp_cnt = exp_cnt + 8'd1;
      finish_switch(1'b1);
      chk("t4_count_total", 32'(switch_count_o), 3);

      // 5: reset during RESET_HOLD at rst_cnt == 5
      start_switch(1'b0);
      sb_q.push_back('{dvi: 1'b0, cnt: exp_cnt + 8'd1});
      exp_cnt = exp_cnt + 8'd1;
      finish_switch(1'b0);
      start_switch(1'b1);
      tick(4);
      pulse_eof();
      chk("t5_dvi_before_reset", 32'(dvi_output_o), 1);
      tick(10);
      chk("t5_core_reset_before_reset", 32'(core_reset_o), 1);
      rst     = 1'b1;
      dvi_req = 1'b0;
      #1;
      chk("t5_async_dvi", 32'(dvi_output_o), 0);
      chk("t5_async_count", 32'(switch_count_o), 0);
      chk("t5_async_blank", 32'(blank_o), 1);
      chk("t5_async_busy", 32'(busy_o), 1);
      chk("t5_async_core_reset", 32'(core_reset_o), 1);
      tick(2);
      exp_dvi = 1'b0;
      exp_cnt = 8'd0;
      sb_q.push_back('{dvi: 1'b0, cnt: 8'd0});
      rst = 1'b0;
      measure_reset(n);
      chk("t5_core_reset_len", 32'(n), RC);
      mute_phase(1'b0, 1'b0);

      // 7: 256 switches wrap the counter back to zero
      for (int i = 0; i < 256; i++) begin
         r = ~exp_dvi;
         start_switch(r);
         sb_q.push_back('{dvi: r, cnt: exp_cnt + 8'd1});
         exp_cnt = exp_cnt + 8'd1;
         finish_switch(r);
         if (i == 254) chk("t7_count_255", 32'(switch_count_o), 255);
      end
      chk("t7_count_wrapped", 32'(switch_count_o), 0);
      chk("sb_drained", 32'(sb_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
